opc_reader: RTL and testbench
=============================

OPC_READER -- requirements
Module: opc_reader

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc  input  14  current micro-PC to be recorded.
REQ-005 state_fetch  input  1  fetch state; capture qualifier.
REQ-006 opcclk  input  1  explicit old-PC clock; capture qualifier.
REQ-007 opcinh  input  1  old-PC inhibit; blocks capture.
REQ-008 spy_start  input  1  debug request to open a read session.
REQ-009 spy_rd  input  1  debug request for the next history entry.
REQ-010 spy_opc  output  14  history entry returned to the debug side.
REQ-011 spy_valid  output  1  one-cycle strobe; spy_opc valid.
REQ-012 spy_busy  output  1  read session active; history frozen.
REQ-013 spy_done  output  1  one-cycle strobe; session complete.
REQ-014 opc_count  output  4  number of valid entries, 0..8.

Function
REQ-015 The block SHALL hold an 8-entry x 14-bit circular history, a 3-bit write pointer and a 4-bit count.
REQ-016 The capture condition SHALL be (state_fetch | opcclk) & ~opcinh & ~spy_busy.
REQ-017 On capture, pc SHALL be written at the write pointer. The write pointer SHALL increment modulo 8 (7 wraps to 0).
REQ-018 On capture, count SHALL increment and saturate at 8. Once full, each capture SHALL overwrite the oldest entry.
REQ-019 The FSM SHALL have states IDLE, READ and DONE. Reset SHALL enter IDLE.
REQ-020 In IDLE, spy_start with count != 0 SHALL load read pointer = write pointer - 1 (mod 8) and remaining = count, then enter READ.
REQ-021 In IDLE, spy_start with count == 0 SHALL enter DONE directly, with no spy_valid.
REQ-022 A capture in the same cycle as an accepted spy_start SHALL be suppressed.
REQ-023 In READ, spy_rd in cycle N SHALL cause spy_opc = entry[read pointer] and spy_valid = 1 in cycle N+1, where the read pointer is sampled in cycle N.
REQ-024 Each accepted spy_rd SHALL decrement the read pointer modulo 8 and decrement remaining. Entries SHALL be returned newest first.
REQ-025 spy_rd SHALL be accepted on back-to-back cycles.
REQ-026 When remaining reaches 0, the FSM SHALL enter DONE.
REQ-027 spy_done SHALL be high for exactly one cycle: the cycle after the last spy_valid, or the cycle after spy_start in the empty case. The FSM SHALL then return to IDLE.
REQ-028 spy_busy SHALL be high from the cycle after spy_start is accepted through the spy_done cycle, inclusive.
REQ-029 Capture SHALL resume in the cycle after spy_done.
REQ-030 spy_rd in IDLE or DONE SHALL be ignored.
REQ-031 spy_start while spy_busy is high SHALL be ignored.
REQ-032 spy_opc SHALL hold its last value when spy_valid is low.
REQ-033 opc_count SHALL reflect the registered count and SHALL not change during a session.

Reset
REQ-034 When reset is low, the block SHALL asynchronously clear the write pointer, read pointer, count, remaining, spy_opc, spy_valid, spy_busy and spy_done to 0, and set the FSM to IDLE.
REQ-035 History contents SHALL not be required to reset.
REQ-036 Reset asserted mid-session SHALL abort the session with no spy_done.

Configuration
REQ-037 With macro OPCS_READ_CLEAR_EN defined, count SHALL clear to 0 in the spy_done cycle; the write pointer SHALL be unchanged.
REQ-038 Without OPCS_READ_CLEAR_EN, history and count SHALL be retained after a session.

Verification
REQ-039 Capture 3 PCs 0x0100, 0x0101, 0x0102; spy_start; three spy_rd -> spy_opc 0x0102, 0x0101, 0x0100; opc_count = 3; spy_done one cycle after the third spy_valid.
REQ-040 Capture 10 PCs 0x0000..0x0009 -> opc_count = 8; a full read returns 0x0009 down to 0x0002 (wrap verified).
REQ-041 Hold opcinh = 1 with state_fetch = 1 for 5 cycles -> opc_count unchanged.
REQ-042 During READ, toggle state_fetch with pc = 0x3FFF -> no capture; after spy_done, the next capture is recorded and count increments.
REQ-043 spy_start with count = 0 -> spy_busy high 1 cycle, spy_done pulse, no spy_valid.
REQ-044 Drive reset low after 1 of 4 reads -> all outputs 0, FSM IDLE, no spy_done. With OPCS_READ_CLEAR_EN, a completed session leaves opc_count = 0.

Source files
------------

// File: rtl/opc_reader.sv
// Old-PC history recorder: 8-deep circular log of micro-PCs with a debug read-out session.
// Define OPCS_READ_CLEAR_EN to clear the entry count when a read session completes.
module opc_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] pc,
    input  logic        state_fetch,
    input  logic        opcclk,
    input  logic        opcinh,
    input  logic        spy_start,
    input  logic        spy_rd,
    output logic [13:0] spy_opc,
    output logic        spy_valid,
    output logic        spy_busy,
    output logic        spy_done,
    output logic [3:0]  opc_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [13:0] hist [0:7];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;
    logic [3:0]  remaining;
    logic        start_ok;
    logic        capture;

    // Handshake: spy_start is taken only in IDLE; spy_rd only in READ; spy_valid and
    // spy_done are single-cycle strobes and spy_busy frames the whole session.
    assign start_ok = (state == IDLE) && spy_start;
    // A capture coinciding with an accepted spy_start is dropped so the session snapshot is stable.
    assign capture  = (state_fetch | opcclk) & ~opcinh & ~spy_busy & ~start_ok;

    assign opc_count = count;
    assign dbg_state = state;

    // History storage carries no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (capture) begin
            hist[wr_ptr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            count     <= 4'd0;
            remaining <= 4'd0;
            spy_opc   <= 14'd0;
            spy_valid <= 1'b0;
            spy_busy  <= 1'b0;
            spy_done  <= 1'b0;
        end else begin
            spy_valid <= 1'b0;

            if (capture) begin
                wr_ptr <= wr_ptr + 3'd1;
                if (count != 4'd8) begin
                    count <= count + 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    spy_done <= 1'b0;
                    if (spy_start) begin
                        spy_busy <= 1'b1;
                        if (count != 4'd0) begin
                            rd_ptr    <= wr_ptr - 3'd1;
                            remaining <= count;
                            state     <= READ;
                        end else begin
                            // Empty history: the done strobe follows the start directly.
                            spy_done <= 1'b1;
                            state    <= DONE;
`ifdef OPCS_READ_CLEAR_EN
                            count    <= 4'd0;
`endif
                        end
                    end
                end

                READ: begin
                    if (spy_rd) begin
                        spy_opc   <= hist[rd_ptr];
                        spy_valid <= 1'b1;
                        rd_ptr    <= rd_ptr - 3'd1;
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    // Arrive here with spy_done low after the last read; raise it for one cycle.
                    if (!spy_done) begin
                        spy_done <= 1'b1;
`ifdef OPCS_READ_CLEAR_EN
                        count    <= 4'd0;
`endif
                    end else begin
                        spy_done <= 1'b0;
                        spy_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    spy_busy <= 1'b0;
                    spy_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opc_reader.sv
// Directed bench for opc_reader: capture, saturation/wrap, inhibit, empty and aborted sessions.
module tb_opc_reader;

    logic        clk;
    logic        reset;
    logic [13:0] pc;
    logic        state_fetch;
    logic        opcclk;
    logic        opcinh;
    logic        spy_start;
    logic        spy_rd;
    logic [13:0] spy_opc;
    logic        spy_valid;
    logic        spy_busy;
    logic        spy_done;
    logic [3:0]  opc_count;
    logic [1:0]  dbg_state;

    int          checks;
    int          errors;
    int          exp_count;
    logic [13:0] exp_q[$];

    opc_reader dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .state_fetch (state_fetch),
        .opcclk      (opcclk),
        .opcinh      (opcinh),
        .spy_start   (spy_start),
        .spy_rd      (spy_rd),
        .spy_opc     (spy_opc),
        .spy_valid   (spy_valid),
        .spy_busy    (spy_busy),
        .spy_done    (spy_done),
        .opc_count   (opc_count),
        .dbg_state   (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // model of the history: newest at the back, at most 8 entries
    task automatic model_capture(input logic [13:0] v);
        exp_q.push_back(v);
        if (exp_q.size() > 8) void'(exp_q.pop_front());
        if (exp_count < 8) exp_count++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, spy_valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, spy_busy},  32'd0);
        check({tag, "_done"},  {31'd0, spy_done},  32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_count   = 0;
        reset       = 1'b0;
        pc          = 14'd0;
        state_fetch = 1'b0;
        opcclk      = 1'b0;
        opcinh      = 1'b0;
        spy_start   = 1'b0;
        spy_rd      = 1'b0;

        // reset state
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_opc",   {18'd0, spy_opc},   32'd0);
        check("rst_count", {28'd0, opc_count}, 32'd0);
        reset = 1'b1;
        tick();

        // empty session: busy and done for a single cycle, no valid
        spy_start = 1'b1;
        tick();
        spy_start = 1'b0;
        check("empty_busy",  {31'd0, spy_busy},  32'd1);
        check("empty_done",  {31'd0, spy_done},  32'd1);
        check("empty_valid", {31'd0, spy_valid}, 32'd0);
        check("empty_state", {30'd0, dbg_state}, 32'd2);
        tick();
        check_idle_outputs("empty_end");

        // spy_rd outside a session does nothing
        spy_rd = 1'b1;
        tick();
        spy_rd = 1'b0;
        check("idle_rd_valid", {31'd0, spy_valid}, 32'd0);

        // three captures
        state_fetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 14'h0100 + 14'(i);
            tick();
            model_capture(pc);
        end
        state_fetch = 1'b0;
        check("cap3_count", {28'd0, opc_count}, 32'd3);

        // session with a fetch in the start cycle and fetches toggling during READ
        pc          = 14'h3FFF;
        state_fetch = 1'b1;
        spy_start   = 1'b1;
        tick();
        spy_start = 1'b0;
        check("s1_busy",  {31'd0, spy_busy},  32'd1);
        check("s1_state", {30'd0, dbg_state}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            spy_rd      = 1'b1;
            state_fetch = i[0];
            tick();
            check("s1_valid", {31'd0, spy_valid}, 32'd1);
            check("s1_opc",   {18'd0, spy_opc},   32'h0102 - i);
            check("s1_model", {18'd0, spy_opc},   {18'd0, exp_q[exp_q.size() - 1 - i]});
            check("s1_count", {28'd0, opc_count}, 32'd3);
        end
        spy_rd      = 1'b0;
        state_fetch = 1'b0;
        tick();
`ifdef OPCS_READ_CLEAR_EN
        exp_count = 0;
`endif
        check("s1_done",     {31'd0, spy_done},  32'd1);
        check("s1_done_vld", {31'd0, spy_valid}, 32'd0);
        check("s1_hold_opc", {18'd0, spy_opc},   32'h0100);
        check("s1_done_cnt", {28'd0, opc_count}, exp_count);
        // fetch held: blocked in the done cycle, recorded in the following one
        pc          = 14'h0200;
        state_fetch = 1'b1;
        tick();
        check_idle_outputs("s1_end");
        check("s1_end_cnt", {28'd0, opc_count}, exp_count);
        tick();
        state_fetch = 1'b0;
        model_capture(14'h0200);
        check("resume_cnt", {28'd0, opc_count}, exp_count);

        // inhibit blocks capture
        pc          = 14'h0555;
        state_fetch = 1'b1;
        opcinh      = 1'b1;
        repeat (5) tick();
        state_fetch = 1'b0;
        opcinh      = 1'b0;
        check("inh_count", {28'd0, opc_count}, exp_count);

        // ten captures, alternating qualifiers, saturates and wraps
        for (int i = 0; i < 10; i++) begin
            pc          = 14'(i);
            state_fetch = i[0];
            opcclk      = ~i[0];
            tick();
            model_capture(pc);
        end
        state_fetch = 1'b0;
        opcclk      = 1'b0;
        check("sat_count", {28'd0, opc_count}, 32'd8);

        spy_start = 1'b1;
        tick();
        spy_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spy_rd    = 1'b1;
            spy_start = (i == 1);
            tick();
            check("full_valid", {31'd0, spy_valid}, 32'd1);
            check("full_opc",   {18'd0, spy_opc},   32'd9 - i);
        end
        spy_rd    = 1'b0;
        spy_start = 1'b0;
        tick();
`ifdef OPCS_READ_CLEAR_EN
        exp_count = 0;
`endif
        check("full_done",     {31'd0, spy_done},  32'd1);
        check("full_done_cnt", {28'd0, opc_count}, exp_count);
        tick();
        check_idle_outputs("full_end");

        // reset mid-session aborts without a done strobe
        if (exp_count == 0) begin
            state_fetch = 1'b1;
            repeat (4) begin
                pc = pc + 14'd1;
                tick();
            end
            state_fetch = 1'b0;
        end
        spy_start = 1'b1;
        tick();
        spy_start = 1'b0;
        spy_rd    = 1'b1;
        tick();
        spy_rd = 1'b0;
        check("abort_valid", {31'd0, spy_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_opc",   {18'd0, spy_opc},   32'd0);
        check("abort_count", {28'd0, opc_count}, 32'd0);
        tick();
        tick();
        check("abort_nodone", {31'd0, spy_done}, 32'd0);
        reset = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
